div_rate_sched: RTL

Rate scheduler for the lab's clock-division datapath. It owns the 2-bit divide select, accepts "faster"/"slower" button pulses, and maps the select to a divide count. It runs the division counter that produces a one-cycle `tick` and a square `slow_clk`. Select changes are deferred to the next period boundary so that no output period is ever truncated or stretched. It sits between the debounced push-button logic and the display/counter blocks that consume `tick`.

---
 rtl/div_rate_pkg.sv | 47 ++++
 rtl/div_n_lut.sv | 28 ++
 rtl/div_rate_sched.sv | 91 +++++++++
 3 files changed

// File: rtl/div_rate_pkg.sv
// ---------------------------------------------------------------------------
// div_rate_pkg
// Shared definitions for the clock-division rate scheduler.
//   CNT_W_DEF     : default width of the divide count / period counter
//   rate_sel_t    : 2-bit divide select (00 = fastest, 11 = slowest)
//   DIVN_0..3     : divide counts per select value
//   SEL_RST       : select value after reset (slowest rate)
//   sel_step()    : one saturating faster/slower step on a select value
// Build option: define DIV_SIM_FAST_EN to shrink the divide counts
// (5/10/20/40) so simulations reach period boundaries quickly.
// ---------------------------------------------------------------------------
package div_rate_pkg;

   localparam int CNT_W_DEF = 32;

   typedef logic [1:0] rate_sel_t;

`ifdef DIV_SIM_FAST_EN
   localparam int DIVN_0 = 5;
   localparam int DIVN_1 = 10;
   localparam int DIVN_2 = 20;
   localparam int DIVN_3 = 40;
`else
   localparam int DIVN_0 = 312500;
   localparam int DIVN_1 = 625000;
   localparam int DIVN_2 = 1250000;
   localparam int DIVN_3 = 2500000;
`endif

   localparam rate_sel_t SEL_RST = 2'b11;

   // One request step on a select value. "faster" lowers the select,
   // "slower" raises it, both saturate; simultaneous requests cancel.
   function automatic rate_sel_t sel_step(input rate_sel_t cur,
                                          input logic      faster,
                                          input logic      slower);
      rate_sel_t res;
      res = cur;
      if (faster && !slower) begin
         if (cur != 2'b00) res = cur - 2'b01;
      end else if (slower && !faster) begin
         if (cur != 2'b11) res = cur + 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/div_n_lut.sv
// ---------------------------------------------------------------------------
// div_n_lut
// Purely combinational map from a rate select to its divide count.
// Ports:
//   i_sel  : rate select (rate_sel_t)
//   o_divn : divide count for that select, CNT_W bits
// Values come from div_rate_pkg and follow the DIV_SIM_FAST_EN build option.
// ---------------------------------------------------------------------------
module div_n_lut
   import div_rate_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic [1:0]       i_sel,
   output logic [CNT_W-1:0] o_divn
);

   always_comb begin
      o_divn = CNT_W'(DIVN_3);
      case (i_sel)
         2'b00:   o_divn = CNT_W'(DIVN_0);
         2'b01:   o_divn = CNT_W'(DIVN_1);
         2'b10:   o_divn = CNT_W'(DIVN_2);
         default: o_divn = CNT_W'(DIVN_3);
      endcase
   end

endmodule

// File: rtl/div_rate_sched.sv
// ---------------------------------------------------------------------------
// div_rate_sched
// Rate scheduler for the clock-division datapath. Owns the 2-bit divide
// select, folds "faster"/"slower" button pulses into a pending select,
// and runs the period counter that produces a one-cycle tick and a
// square slow_clk. A pending select is only committed at a period
// boundary (or on any edge while stopped), so no period is ever cut short
// or stretched.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   en       : run enable; low freezes counting and clears the phase
//   faster   : one-cycle request to lower the select (shorter period)
//   slower   : one-cycle request to raise the select (longer period)
//   sel      : active select
//   sel_pend : select to be applied at the next boundary
//   divn     : active divide count (map of sel)
//   tick     : high on the last cycle of each period
//   slow_clk : toggles on every tick, period 2*divn
// Build option: DIV_SIM_FAST_EN selects the short simulation divide map.
// ---------------------------------------------------------------------------
module div_rate_sched
   import div_rate_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             faster,
   input  logic             slower,
   output logic [1:0]       sel,
   output logic [1:0]       sel_pend,
   output logic [CNT_W-1:0] divn,
   output logic             tick,
   output logic             slow_clk
);

   rate_sel_t        r_sel;
   rate_sel_t        r_sel_pend;
   logic [CNT_W-1:0] r_cnt;
   logic             r_slow_clk;

   rate_sel_t        w_pend_next;
   logic [CNT_W-1:0] w_divn;
   logic             w_tick;

   // divn always follows the committed select, never the pending one.
   div_n_lut #(
      .CNT_W (CNT_W)
   ) u_lut (
      .i_sel  (r_sel),
      .o_divn (w_divn)
   );

   // A request on the boundary cycle lands in the pending value first,
   // and that updated value is what gets committed on the same edge.
   assign w_pend_next = sel_step(r_sel_pend, faster, slower);

   assign w_tick = en && (r_cnt == (w_divn - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel      <= SEL_RST;
         r_sel_pend <= SEL_RST;
         r_cnt      <= '0;
         r_slow_clk <= 1'b0;
      end else begin
         r_sel_pend <= w_pend_next;
         if (!en) begin
            // Stopped: adopt the pending rate immediately and rewind the
            // phase so a restart runs a full period at the new rate.
            r_cnt <= '0;
            r_sel <= w_pend_next;
         end else if (w_tick) begin
            r_cnt      <= '0;
            r_slow_clk <= ~r_slow_clk;
            r_sel      <= w_pend_next;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign sel      = r_sel;
   assign sel_pend = r_sel_pend;
   assign divn     = w_divn;
   assign tick     = w_tick;
   assign slow_clk = r_slow_clk;

endmodule
